// File: rtl/store_pkg.sv
// Shared types and lane helpers for the store narrowing path.
package store_pkg;

  localparam int unsigned LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    ERR
  } state_e;

  // Little-endian lanes touched by a store of the given size at byte offset a.
  function automatic logic [LANES-1:0] lane_mask(size_e sz, logic [1:0] a);
    case (sz)
      SZ_BYTE: lane_mask = 4'b0001 << a;
      SZ_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Narrowed value copied into every lane, so any lane can be selected by mask.
  function automatic logic [31:0] lane_replicate(size_e sz, logic [31:0] d);
    case (sz)
      SZ_BYTE: lane_replicate = {4{d[7:0]}};
      SZ_HALF: lane_replicate = {2{d[15:0]}};
      default: lane_replicate = d;
    endcase
  endfunction

  function automatic logic is_misaligned(size_e sz, logic [1:0] a);
    case (sz)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = a[0];
      SZ_WORD: is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: inserts the narrowed store value into an existing word.
module store_lane_merge
  import store_pkg::*;
(
  input  logic [31:0]      i_old,
  input  logic [31:0]      i_data,
  input  size_e            i_size,
  input  logic [1:0]       i_addr_lo,
  output logic [31:0]      o_merged,
  output logic [LANES-1:0] o_mask
);

  logic [31:0] w_rep;

  always_comb begin
    o_mask   = lane_mask(i_size, i_addr_lo);
    w_rep    = lane_replicate(i_size, i_data);
    o_merged = i_old;
    for (int i = 0; i < int'(LANES); i++) begin
      if (o_mask[i]) o_merged[8*i +: 8] = w_rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: byte/half/word stores into word-wide memory.
// MEM_BYTE_MASK_EN selects byte-enable writes instead of read-modify-write.
module store_narrow_unit
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              done,
  output logic              err
`ifdef MEM_BYTE_MASK_EN
  ,
  output logic [LANES-1:0]  mem_be
`endif
);

  state_e            r_state;
  logic              r_req_ready;
  logic              r_mem_rd_en;
  logic              r_mem_wr_en;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  size_e             w_req_size;
  logic              w_bad;
  logic [31:0]       w_merged;
  logic [LANES-1:0]  w_mask;
  logic              w_unused;

  assign w_req_size = size_e'(req_size);
  assign w_bad      = is_misaligned(w_req_size, req_addr[1:0]);

`ifdef MEM_BYTE_MASK_EN
  logic [LANES-1:0] r_mem_be;

  // Only the lane mask of the incoming request is needed here.
  store_lane_merge u_merge (
    .i_old     (mem_rdata),
    .i_data    (req_data),
    .i_size    (w_req_size),
    .i_addr_lo (req_addr[1:0]),
    .o_merged  (w_merged),
    .o_mask    (w_mask)
  );

  assign mem_be   = r_mem_be;
  assign w_unused = ^{mem_rdata, mem_rvalid, w_merged};
`else
  logic [DATA_W-1:0] r_data;
  size_e             r_size;
  logic [1:0]        r_addr_lo;

  // Merge the fetched word with the request captured at acceptance.
  store_lane_merge u_merge (
    .i_old     (mem_rdata),
    .i_data    (r_data),
    .i_size    (r_size),
    .i_addr_lo (r_addr_lo),
    .o_merged  (w_merged),
    .o_mask    (w_mask)
  );

  assign w_unused = ^w_mask;
`endif

  assign req_ready = r_req_ready;
  assign mem_addr  = r_mem_addr;
  assign mem_rd_en = r_mem_rd_en;
  assign mem_wr_en = r_mem_wr_en;
  assign mem_wdata = r_mem_wdata;
  assign done      = r_done;
  assign err       = r_err;

  // Strobes are single-cycle: cleared every cycle unless a transition sets them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_mem_rd_en <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifdef MEM_BYTE_MASK_EN
      r_mem_be    <= '0;
`else
      r_data      <= '0;
      r_size      <= SZ_BYTE;
      r_addr_lo   <= 2'b00;
`endif
    end else begin
      r_mem_rd_en <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef MEM_BYTE_MASK_EN
      r_mem_be    <= '0;
`endif
      case (r_state)
        IDLE: begin
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
`ifndef MEM_BYTE_MASK_EN
            r_data      <= req_data;
            r_size      <= w_req_size;
            r_addr_lo   <= req_addr[1:0];
`endif
            if (w_bad) begin
              r_state <= ERR;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
`ifdef MEM_BYTE_MASK_EN
            else begin
              r_state     <= WRITE;
              r_mem_wr_en <= 1'b1;
              r_done      <= 1'b1;
              r_mem_wdata <= lane_replicate(w_req_size, req_data);
              r_mem_be    <= w_mask;
            end
`else
            else if (w_req_size == SZ_WORD) begin
              r_state     <= WRITE;
              r_mem_wr_en <= 1'b1;
              r_done      <= 1'b1;
              r_mem_wdata <= req_data;
            end else begin
              r_state     <= READ;
              r_mem_rd_en <= 1'b1;
            end
`endif
          end
        end
`ifndef MEM_BYTE_MASK_EN
        READ: r_state <= WAIT;
        WAIT: begin
          if (mem_rvalid) begin
            r_state     <= WRITE;
            r_mem_wr_en <= 1'b1;
            r_done      <= 1'b1;
            r_mem_wdata <= w_merged;
          end
        end
`endif
        WRITE, ERR: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Randomized bench for store_narrow_unit against a word-memory reference model.
module tb_store_narrow_unit;

`ifdef MEM_BYTE_MASK_EN
  localparam bit MASK_MODE = 1'b1;
`else
  localparam bit MASK_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic        done;
  logic        err;
`ifdef MEM_BYTE_MASK_EN
  logic [3:0]  mem_be;
`endif

  int total = 0;
  int bad = 0;

  logic [31:0] ref_mem [logic [31:0]];

  typedef struct {
    logic        ready_req;
    int          rd_cnt, rd_at, wr_cnt, wr_at, done_cnt, done_at, err_cnt;
    logic        ready_after, done_after;
    logic [31:0] rd_addr, wr_addr, wdata;
    logic [3:0]  be;
  } obs_t;

  store_narrow_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_size   (req_size),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_wr_en  (mem_wr_en),
    .mem_wdata  (mem_wdata),
    .done       (done),
    .err        (err)
`ifdef MEM_BYTE_MASK_EN
    ,
    .mem_be     (mem_be)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mem_get(logic [31:0] wa);
    if (!ref_mem.exists(wa)) ref_mem[wa] = $urandom;
    return ref_mem[wa];
  endfunction

  function automatic logic [31:0] rand_word_addr();
    return 32'h1000 + 32'(4 * $urandom_range(0, 15));
  endfunction

  // Memory word after a store: replace the addressed bytes, keep the rest.
  function automatic logic [31:0] model_merge(logic [31:0] old, logic [31:0] d,
                                              logic [1:0] sz, logic [1:0] a);
    int unsigned sh;
    logic [31:0] m;
    case (sz)
      2'b00:   begin sh = 8 * a;     m = 32'hFF << sh;   end
      2'b01:   begin sh = 16 * a[1]; m = 32'hFFFF << sh; end
      default: begin sh = 0;         m = 32'hFFFF_FFFF;  end
    endcase
    return (old & ~m) | ((d << sh) & m);
  endfunction

  function automatic logic [31:0] model_repl(logic [31:0] d, logic [1:0] sz);
    logic [31:0] b, h;
    b = d & 32'hFF;
    h = d & 32'hFFFF;
    case (sz)
      2'b00:   return b * 32'h0101_0101;
      2'b01:   return h * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] model_be(logic [1:0] sz, logic [1:0] a);
    case (sz)
      2'b00:   return 4'(1 << a);
      2'b01:   return 4'(3 << (2 * a[1]));
      default: return 4'hF;
    endcase
  endfunction

  // Drives one request, serves the read from ref_mem after dly cycles and records what the DUT did.
  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                           input int dly, input bit noise, output obs_t o);
    o = '{ready_req: 1'b0, rd_cnt: 0, rd_at: 0, wr_cnt: 0, wr_at: 0, done_cnt: 0, done_at: 0,
           err_cnt: 0, ready_after: 1'b0, done_after: 1'b1, rd_addr: '0, wr_addr: '0,
           wdata: '0, be: '0};
    req_addr  = a;
    req_data  = d;
    req_size  = sz;
    req_valid = 1'b1;
    o.ready_req = req_ready;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      req_valid  = 1'b0;
      mem_rvalid = 1'b0;
      if (mem_rd_en) begin
        o.rd_cnt++;
        if (o.rd_at == 0) begin o.rd_at = k; o.rd_addr = mem_addr; end
      end
      if (mem_wr_en) begin
        o.wr_cnt++;
        o.wr_at   = k;
        o.wr_addr = mem_addr;
        o.wdata   = mem_wdata;
`ifdef MEM_BYTE_MASK_EN
        o.be      = mem_be;
`endif
      end
      if (err) o.err_cnt++;
      if (o.done_at != 0 && k == o.done_at + 1) begin
        o.ready_after = req_ready;
        o.done_after  = done;
        break;
      end
      if (done) begin o.done_cnt++; o.done_at = k; end
      if (o.rd_at != 0 && k == o.rd_at + dly) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_get({a[31:2], 2'b00});
      end else if (noise && o.rd_at != 0 && k == o.rd_at) begin
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    total++;
    if ({mem_rd_en, mem_wr_en, done, err} !== 4'b0000) begin
      bad++; $display("FAIL reset_strobes: got %b want 0000", {mem_rd_en, mem_wr_en, done, err});
    end
    total++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      bad++; $display("FAIL reset_buses: got addr %h wdata %h want 0", mem_addr, mem_wdata);
    end
`ifdef MEM_BYTE_MASK_EN
    total++;
    if (mem_be !== 4'b0000) begin bad++; $display("FAIL reset_be: got %b want 0000", mem_be); end
`endif
  endtask

  task automatic test_word();
    obs_t o;
    logic [31:0] a, d;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin a = 32'h100; d = 32'hDEADBEEF; end
      else begin a = rand_word_addr(); d = $urandom; end
      run_store(a, d, 2'b10, 1, 1'b0, o);
      ref_mem[a] = d;
      total++;
      if (o.wdata !== d) begin bad++; $display("FAIL word_wdata a=%h: got %h want %h", a, o.wdata, d); end
      total++;
      if (o.wr_addr !== a) begin bad++; $display("FAIL word_addr: got %h want %h", o.wr_addr, a); end
      total++;
      if (o.wr_at !== 1 || o.done_at !== 1 || o.wr_cnt !== 1) begin
        bad++; $display("FAIL word_latency: wr_at %0d done_at %0d wr_cnt %0d want 1 1 1", o.wr_at, o.done_at, o.wr_cnt);
      end
      total++;
      if (o.rd_cnt !== 0 || o.err_cnt !== 0) begin
        bad++; $display("FAIL word_no_read: rd_cnt %0d err_cnt %0d want 0 0", o.rd_cnt, o.err_cnt);
      end
      total++;
      if (o.ready_req !== 1'b1 || o.ready_after !== 1'b1 || o.done_after !== 1'b0) begin
        bad++; $display("FAIL word_handshake: ready %b/%b done_after %b want 1/1 0", o.ready_req, o.ready_after, o.done_after);
      end
      total++;
      if (o.be !== (MASK_MODE ? 4'hF : 4'h0)) begin bad++; $display("FAIL word_be: got %b", o.be); end
    end
  endtask

  task automatic test_subword(input logic [1:0] sz);
    obs_t o;
    logic [31:0] a, d, wa, old, want, exp_wd;
    int dly, exp_wr;
    for (int i = 0; i < 10; i++) begin
      dly = $urandom_range(1, 5);
      if (i == 0 && sz == 2'b00) begin
        a = 32'h203; d = 32'h0000_00AB; ref_mem[32'h200] = 32'h1122_3344; dly = 3;
      end else if (i == 1 && sz == 2'b00) begin
        a = 32'h201; d = 32'h0000_007F;
      end else if (i == 0) begin
        a = 32'h302; d = 32'hFFFF_5A5A; ref_mem[32'h300] = 32'hCAFE_F00D;
      end else begin
        a = rand_word_addr() + 32'(sz == 2'b00 ? $urandom_range(0, 3) : 2 * $urandom_range(0, 1));
        d = $urandom;
      end
      wa  = {a[31:2], 2'b00};
      old = mem_get(wa);
      run_store(a, d, sz, dly, i[0], o);
      want = model_merge(old, d, sz, a[1:0]);
      ref_mem[wa] = want;
      exp_wd = MASK_MODE ? model_repl(d, sz) : want;
      exp_wr = MASK_MODE ? 1 : dly + 2;
      total++;
      if (o.wdata !== exp_wd) begin
        bad++; $display("FAIL sub_wdata sz=%0d a=%h: got %h want %h", sz, a, o.wdata, exp_wd);
      end
      total++;
      if (o.wr_addr !== wa) begin bad++; $display("FAIL sub_addr: got %h want %h", o.wr_addr, wa); end
      total++;
      if (o.wr_at !== exp_wr || o.done_at !== exp_wr || o.wr_cnt !== 1) begin
        bad++; $display("FAIL sub_latency sz=%0d dly=%0d: wr_at %0d done_at %0d wr_cnt %0d want %0d", sz, dly, o.wr_at, o.done_at, o.wr_cnt, exp_wr);
      end
      total++;
      if (o.rd_cnt !== (MASK_MODE ? 0 : 1) || (!MASK_MODE && (o.rd_at !== 1 || o.rd_addr !== wa))) begin
        bad++; $display("FAIL sub_read: rd_cnt %0d rd_at %0d rd_addr %h", o.rd_cnt, o.rd_at, o.rd_addr);
      end
      total++;
      if (o.be !== (MASK_MODE ? model_be(sz, a[1:0]) : 4'h0)) begin
        bad++; $display("FAIL sub_be a=%h: got %b want %b", a, o.be, MASK_MODE ? model_be(sz, a[1:0]) : 4'h0);
      end
      total++;
      if (o.err_cnt !== 0 || o.ready_after !== 1'b1) begin
        bad++; $display("FAIL sub_retire: err_cnt %0d ready_after %b want 0 1", o.err_cnt, o.ready_after);
      end
    end
  endtask

  task automatic test_errors();
    obs_t o;
    logic [31:0] a;
    logic [1:0] sz;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin a = 32'h301; sz = 2'b01; end
        1: begin a = 32'h102; sz = 2'b10; end
        2: begin a = 32'h100; sz = 2'b11; end
        default: begin
          sz = 2'($urandom_range(1, 3));
          a  = rand_word_addr() + 32'(sz == 2'b01 ? (2 * $urandom_range(0, 1) + 1) : $urandom_range(1, 3));
          if (sz == 2'b11) a = $urandom;
        end
      endcase
      run_store(a, $urandom, sz, 1, 1'b0, o);
      total++;
      if (o.done_at !== 1 || o.err_cnt !== 1 || o.done_cnt !== 1) begin
        bad++; $display("FAIL err_pulse a=%h sz=%0d: done_at %0d err_cnt %0d want 1 1", a, sz, o.done_at, o.err_cnt);
      end
      total++;
      if (o.rd_cnt !== 0 || o.wr_cnt !== 0) begin
        bad++; $display("FAIL err_no_access: rd_cnt %0d wr_cnt %0d want 0 0", o.rd_cnt, o.wr_cnt);
      end
      total++;
      if (o.done_after !== 1'b0 || o.ready_after !== 1'b1) begin
        bad++; $display("FAIL err_retire: done_after %b ready_after %b want 0 1", o.done_after, o.ready_after);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit wr_seen;
    wr_seen   = 1'b0;
    req_addr  = 32'h400;
    req_data  = 32'h0000_0055;
    req_size  = 2'b00;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem_rd_en, mem_wr_en, done, err} !== 4'b0000 || {mem_addr, mem_wdata} !== 64'h0) begin
      bad++; $display("FAIL midrst_outputs: strobes %b addr %h wdata %h want 0", {mem_rd_en, mem_wr_en, done, err}, mem_addr, mem_wdata);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h9999_9999;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      if (mem_wr_en || done) wr_seen = 1'b1;
    end
    total++;
    if (wr_seen !== 1'b0) begin bad++; $display("FAIL midrst_no_write: got write/done after abort want none"); end
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d0, d1;
    d0 = $urandom;
    d1 = $urandom;
    req_addr  = 32'h500;
    req_data  = d0;
    req_size  = 2'b10;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h504;
    req_data = d1;
    total++;
    if (mem_wr_en !== 1'b1 || req_ready !== 1'b0 || mem_wdata !== d0) begin
      bad++; $display("FAIL b2b_first: wr %b ready %b wdata %h want 1 0 %h", mem_wr_en, req_ready, mem_wdata, d0);
    end
    @(posedge clk); #1;
    total++;
    if (mem_wr_en !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_gap: wr %b ready %b want 0 1", mem_wr_en, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if (mem_wr_en !== 1'b1 || mem_wdata !== d1 || mem_addr !== 32'h504) begin
      bad++; $display("FAIL b2b_second: wr %b wdata %h addr %h want 1 %h 504", mem_wr_en, mem_wdata, mem_addr, d1);
    end
    @(posedge clk); #1;
    total++;
    if (mem_wr_en !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_single: wr %b done %b want 0 0", mem_wr_en, done);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword(2'b00);
    test_subword(2'b01);
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
